// File: rtl/omem_pkg.sv
// Shared constants and state encoding for the rotate core's output pixel buffer.
package omem_pkg;

    localparam int DEPTH_DEF       = 192;
    localparam int AW_DEF          = 8;
    localparam int WW_DEF          = 6;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int BYTES_PER_WORD  = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/omem_if.sv
// Pixel-in / word-out bundle of the output buffer.
// Handshakes: a pixel moves on an edge where PIXEL_VALID and PIXEL_READY are both 1;
// a word moves on an edge where WVALID and WACCEPT are both 1, and WDATA is held until then.
interface omem_if
    import omem_pkg::*;
#(
    parameter int WW = WW_DEF
) ();

    logic          I_OMEM_PIXEL_VALID;
    logic [7:0]    I_OMEM_PIXEL_B;
    logic [7:0]    I_OMEM_PIXEL_G;
    logic [7:0]    I_OMEM_PIXEL_R;
    logic          O_OMEM_PIXEL_READY;
    logic          I_OMEM_FLUSH;
    logic          O_OMEM_WVALID;
    logic [31:0]   O_OMEM_WDATA;
    logic          I_OMEM_WACCEPT;
    logic [WW-1:0] O_OMEM_WORD_COUNT;
    logic          O_OMEM_DONE;
    state_t        dbg_state;

    modport slave (
        input  I_OMEM_PIXEL_VALID, I_OMEM_PIXEL_B, I_OMEM_PIXEL_G, I_OMEM_PIXEL_R,
        input  I_OMEM_FLUSH, I_OMEM_WACCEPT,
        output O_OMEM_PIXEL_READY, O_OMEM_WVALID, O_OMEM_WDATA,
        output O_OMEM_WORD_COUNT, O_OMEM_DONE, dbg_state
    );

    modport master (
        output I_OMEM_PIXEL_VALID, I_OMEM_PIXEL_B, I_OMEM_PIXEL_G, I_OMEM_PIXEL_R,
        output I_OMEM_FLUSH, I_OMEM_WACCEPT,
        input  O_OMEM_PIXEL_READY, O_OMEM_WVALID, O_OMEM_WDATA,
        input  O_OMEM_WORD_COUNT, O_OMEM_DONE, dbg_state
    );

endinterface

// File: rtl/omem_word_pack.sv
// Selects the four little-endian byte lanes of word rptr; bytes at or past wptr read as black.
module omem_word_pack
    import omem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int WW    = WW_DEF
) (
    input  logic [8*DEPTH-1:0] mem_flat,
    input  logic [WW-1:0]      rptr,
    input  logic [AW-1:0]      wptr,
    output logic [31:0]        word
);

    logic [AW-1:0] addr;

    always_comb begin
        word = '0;
        addr = '0;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            addr = AW'({rptr, 2'b00}) + AW'(k);
            if (addr < wptr) begin
                word[8*k +: 8] = mem_flat[8*int'(addr) +: 8];
            end
        end
    end

endmodule

// File: rtl/output_mem.sv
// Single output buffer: FILL collects B/G/R bytes, DRAIN hands them out as padded 32-bit words.
module output_mem
    import omem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int WW    = WW_DEF
) (
    input  logic   I_OMEM_HCLK,
    input  logic   I_OMEM_HRESET_N,
    omem_if.slave  bus
);

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [WW-1:0] rptr_q, rptr_d;
    logic [WW-1:0] word_count_q, word_count_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [AW:0]   cnt_sum;

    logic [7:0]         mem_q [DEPTH];
    logic [8*DEPTH-1:0] mem_flat;
    logic [31:0]        pack_word;
    logic               pix_fire;

    // ready_q is only ever 1 in FILL, so it alone gates pixel writes
    assign pix_fire = ready_q & bus.I_OMEM_PIXEL_VALID;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        word_count_d = word_count_q;
        done_d       = 1'b0;
        cnt_sum      = '0;
        case (state_q)
            FILL: begin
                if (pix_fire) begin
                    wptr_d = wptr_q + AW'(BYTES_PER_PIXEL);
                end
                if (wptr_d == AW'(DEPTH) || (bus.I_OMEM_FLUSH && wptr_d != '0)) begin
                    state_d      = DRAIN;
                    rptr_d       = '0;
                    cnt_sum      = {1'b0, wptr_d} + (AW+1)'(BYTES_PER_WORD - 1);
                    word_count_d = WW'(cnt_sum >> 2);
                end
            end
            DRAIN: begin
                if (bus.I_OMEM_WACCEPT) begin
                    if (rptr_q == word_count_q - WW'(1)) begin
                        state_d = FILL;
                        wptr_d  = '0;
                        rptr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        rptr_d = rptr_q + WW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge I_OMEM_HCLK) begin
        if (!I_OMEM_HRESET_N) begin
            state_q      <= FILL;
            wptr_q       <= '0;
            rptr_q       <= '0;
            word_count_q <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            word_count_q <= word_count_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
        end
    end

    // Storage is deliberately left out of reset; stale bytes are masked by wptr.
    always_ff @(posedge I_OMEM_HCLK) begin
        if (pix_fire) begin
            mem_q[wptr_q]           <= bus.I_OMEM_PIXEL_B;
            mem_q[wptr_q + AW'(1)]  <= bus.I_OMEM_PIXEL_G;
            mem_q[wptr_q + AW'(2)]  <= bus.I_OMEM_PIXEL_R;
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[8*i +: 8] = mem_q[i];
        end
    end

    omem_word_pack #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WW    (WW)
    ) u_word_pack (
        .mem_flat (mem_flat),
        .rptr     (rptr_q),
        .wptr     (wptr_q),
        .word     (pack_word)
    );

    assign bus.O_OMEM_PIXEL_READY = ready_q;
    assign bus.O_OMEM_WVALID      = (state_q == DRAIN);
    assign bus.O_OMEM_WDATA       = (state_q == DRAIN) ? pack_word : 32'h0;
    assign bus.O_OMEM_WORD_COUNT  = word_count_q;
    assign bus.O_OMEM_DONE        = done_q;
    assign bus.dbg_state          = state_q;

endmodule

// File: tb/tb_output_mem.sv
// Bench for output_mem: directed vector table, hand sequences, and random traffic against a byte-queue model.
module tb_output_mem;
    import omem_pkg::*;

    localparam int DEPTH = 192;
    localparam int AW    = 8;
    localparam int WW    = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    omem_if #(.WW(WW)) bus ();

    output_mem #(.DEPTH(DEPTH), .AW(AW), .WW(WW)) dut (
        .I_OMEM_HCLK     (clk),
        .I_OMEM_HRESET_N (rst_n),
        .bus             (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: buffered bytes as a queue, words derived from byte positions.
    bit          m_live  = 1'b0;
    bit          m_drain = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_done  = 1'b0;
    int          m_wc    = 0;
    int          m_widx  = 0;
    logic [7:0]  m_bytes[$];

    function automatic logic [31:0] model_word(input int idx);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (4*idx + k < m_bytes.size()) w[8*k +: 8] = m_bytes[4*idx + k];
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            check("mon_ready", 32'(bus.O_OMEM_PIXEL_READY), 32'(m_ready));
            check("mon_wvalid", 32'(bus.O_OMEM_WVALID), 32'(m_drain));
            check("mon_wdata", bus.O_OMEM_WDATA, m_drain ? model_word(m_widx) : 32'h0);
            check("mon_word_count", 32'(bus.O_OMEM_WORD_COUNT), 32'(m_wc));
            check("mon_done", 32'(bus.O_OMEM_DONE), 32'(m_done));
        end
        if (!rst_n) begin
            m_live  = 1'b1;
            m_drain = 1'b0;
            m_ready = 1'b0;
            m_done  = 1'b0;
            m_wc    = 0;
            m_widx  = 0;
            m_bytes.delete();
        end else if (m_live) begin
            m_done = 1'b0;
            if (!m_drain) begin
                if (m_ready && bus.I_OMEM_PIXEL_VALID) begin
                    m_bytes.push_back(bus.I_OMEM_PIXEL_B);
                    m_bytes.push_back(bus.I_OMEM_PIXEL_G);
                    m_bytes.push_back(bus.I_OMEM_PIXEL_R);
                end
                if (m_bytes.size() == DEPTH || (bus.I_OMEM_FLUSH && m_bytes.size() > 0)) begin
                    m_drain = 1'b1;
                    m_wc    = (m_bytes.size() + 3) / 4;
                    m_widx  = 0;
                end
            end else if (bus.I_OMEM_WACCEPT) begin
                if (m_widx == m_wc - 1) begin
                    m_drain = 1'b0;
                    m_done  = 1'b1;
                    m_widx  = 0;
                    m_bytes.delete();
                end else begin
                    m_widx++;
                end
            end
            m_ready = !m_drain;
        end
    end

    typedef struct {
        int          npix;
        logic [7:0]  base;
        bit          flush_last;
        int          stall_at;
        bit          junk;
        int          exp_wc;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic wait_ready(input string tag);
        int c = 0;
        while (bus.O_OMEM_PIXEL_READY !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        check({tag, "_wait_ready"}, 32'(bus.O_OMEM_PIXEL_READY), 32'h1);
    endtask

    task automatic send_pixels(input int npix, input logic [7:0] base, input bit flush_last);
        for (int n = 0; n < npix; n++) begin
            bus.I_OMEM_PIXEL_VALID = 1'b1;
            bus.I_OMEM_PIXEL_B     = base + 8'(3*n);
            bus.I_OMEM_PIXEL_G     = base + 8'(3*n + 1);
            bus.I_OMEM_PIXEL_R     = base + 8'(3*n + 2);
            bus.I_OMEM_FLUSH       = flush_last && (n == npix - 1);
            tick();
        end
        bus.I_OMEM_PIXEL_VALID = 1'b0;
        bus.I_OMEM_FLUSH       = 1'b0;
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        logic [31:0] got[$];
        logic [31:0] stall_val;
        int          stall_cnt = 0;
        int          cyc       = 0;
        bit          done_seen = 1'b0;
        stall_val = '0;
        wait_ready(tag);
        send_pixels(v.npix, v.base, v.flush_last);
        if (!v.flush_last && v.npix * 3 < DEPTH) begin
            bus.I_OMEM_FLUSH = 1'b1;
            tick();
            bus.I_OMEM_FLUSH = 1'b0;
        end
        check({tag, "_wvalid_entry"}, 32'(bus.O_OMEM_WVALID), 32'h1);
        check({tag, "_word_count"}, 32'(bus.O_OMEM_WORD_COUNT), 32'(v.exp_wc));
        while (!done_seen && cyc < 300) begin
            bus.I_OMEM_PIXEL_VALID = v.junk;
            bus.I_OMEM_PIXEL_B     = 8'($urandom);
            bus.I_OMEM_PIXEL_G     = 8'($urandom);
            bus.I_OMEM_PIXEL_R     = 8'($urandom);
            bus.I_OMEM_FLUSH       = v.junk;
            if (got.size() == v.stall_at && stall_cnt < 3) begin
                bus.I_OMEM_WACCEPT = 1'b0;
                if (stall_cnt == 0) stall_val = bus.O_OMEM_WDATA;
                else check({tag, "_stall_hold"}, bus.O_OMEM_WDATA, stall_val);
                check({tag, "_stall_wvalid"}, 32'(bus.O_OMEM_WVALID), 32'h1);
                stall_cnt++;
            end else begin
                bus.I_OMEM_WACCEPT = 1'b1;
                if (bus.O_OMEM_WVALID) got.push_back(bus.O_OMEM_WDATA);
            end
            tick();
            cyc++;
            if (bus.O_OMEM_DONE === 1'b1) done_seen = 1'b1;
        end
        bus.I_OMEM_WACCEPT     = 1'b0;
        bus.I_OMEM_PIXEL_VALID = 1'b0;
        bus.I_OMEM_FLUSH       = 1'b0;
        check({tag, "_done_seen"}, 32'(done_seen), 32'h1);
        check({tag, "_ready_at_done"}, 32'(bus.O_OMEM_PIXEL_READY), 32'h1);
        check({tag, "_words_taken"}, 32'(got.size()), 32'(v.exp_wc));
        if (got.size() > 0) begin
            check({tag, "_first_word"}, got[0], v.exp_first);
            check({tag, "_last_word"}, got[got.size() - 1], v.exp_last);
        end
        if (v.stall_at >= 0 && got.size() > v.stall_at)
            check({tag, "_stalled_word"}, got[v.stall_at], stall_val);
        tick();
        check({tag, "_done_pulse"}, 32'(bus.O_OMEM_DONE), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.O_OMEM_PIXEL_READY), 32'h0);
        check({tag, "_wvalid"}, 32'(bus.O_OMEM_WVALID), 32'h0);
        check({tag, "_wdata"}, bus.O_OMEM_WDATA, 32'h0);
        check({tag, "_word_count"}, 32'(bus.O_OMEM_WORD_COUNT), 32'h0);
        check({tag, "_done"}, 32'(bus.O_OMEM_DONE), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64, 8'h00, 1'b0, -1, 1'b0, 48, 32'h03020100, 32'hBFBEBDBC};
        vecs[1] = '{5,  8'h00, 1'b0, -1, 1'b0, 4,  32'h03020100, 32'h000E0D0C};
        vecs[2] = '{1,  8'h10, 1'b1, -1, 1'b0, 1,  32'h00121110, 32'h00121110};
        vecs[3] = '{8,  8'h40, 1'b0, 2,  1'b1, 6,  32'h43424140, 32'h57565554};
        vecs[4] = '{4,  8'h20, 1'b1, -1, 1'b0, 3,  32'h23222120, 32'h2B2A2928};
        vecs[5] = '{2,  8'hA0, 1'b0, 0,  1'b1, 2,  32'hA3A2A1A0, 32'h0000A5A4};

        bus.I_OMEM_PIXEL_VALID = 1'b0;
        bus.I_OMEM_PIXEL_B     = '0;
        bus.I_OMEM_PIXEL_G     = '0;
        bus.I_OMEM_PIXEL_R     = '0;
        bus.I_OMEM_FLUSH       = 1'b0;
        bus.I_OMEM_WACCEPT     = 1'b0;

        rst_n = 1'b0;
        tick();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_release_ready", 32'(bus.O_OMEM_PIXEL_READY), 32'h1);

        for (int i = 0; i < 6; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Idle: flush on an empty buffer and stray accepts must do nothing.
        bus.I_OMEM_FLUSH   = 1'b1;
        bus.I_OMEM_WACCEPT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_wvalid", 32'(bus.O_OMEM_WVALID), 32'h0);
            check("idle_done", 32'(bus.O_OMEM_DONE), 32'h0);
            check("idle_ready", 32'(bus.O_OMEM_PIXEL_READY), 32'h1);
        end
        bus.I_OMEM_FLUSH   = 1'b0;
        bus.I_OMEM_WACCEPT = 1'b0;
        run_vector(vecs[2], "after_idle");

        // Reset in the middle of a full drain, after ten words.
        wait_ready("mid_reset");
        send_pixels(64, 8'h00, 1'b0);
        check("mid_reset_wvalid", 32'(bus.O_OMEM_WVALID), 32'h1);
        bus.I_OMEM_WACCEPT = 1'b1;
        repeat (10) tick();
        check("mid_reset_word10", bus.O_OMEM_WDATA, 32'h2B2A2928);
        bus.I_OMEM_WACCEPT = 1'b0;
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        tick();
        check("mid_reset_release_ready", 32'(bus.O_OMEM_PIXEL_READY), 32'h1);
        run_vector(vecs[2], "post_reset");

        // Random traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            bus.I_OMEM_PIXEL_VALID = ($urandom_range(0, 9) < 7);
            bus.I_OMEM_PIXEL_B     = 8'($urandom);
            bus.I_OMEM_PIXEL_G     = 8'($urandom);
            bus.I_OMEM_PIXEL_R     = 8'($urandom);
            bus.I_OMEM_FLUSH       = ($urandom_range(0, 19) == 0);
            bus.I_OMEM_WACCEPT     = ($urandom_range(0, 9) < 6);
            rst_n                  = ($urandom_range(0, 999) != 0);
            tick();
        end
        rst_n                  = 1'b1;
        bus.I_OMEM_PIXEL_VALID = 1'b0;
        bus.I_OMEM_FLUSH       = 1'b0;
        bus.I_OMEM_WACCEPT     = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
